// File: rtl/serial_conv_engine.sv
// rtl/serial_conv_engine.sv - 3x3 signed MAC worker for the serial-mode stride handshake
module serial_conv_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int ADDR_W = 8,
    parameter int ROW_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [ADDR_W-1:0]   feature_baseaddr,
    output logic                is_done,
    output logic                busy,
    output logic [ADDR_W-1:0]   f_addr,
    output logic                f_rd,
    input  logic [DATA_W-1:0]   f_rdata,
    output logic [3:0]          w_addr,
    input  logic [DATA_W-1:0]   w_rdata,
    output logic [ACC_W-1:0]    result
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          tap_q, tap_d;
    logic [1:0]          row_q, row_d;
    logic [1:0]          col_q, col_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   last_base_q, last_base_d;
    logic                last_valid_q, last_valid_d;
    logic                en_prev_q, en_prev_d;
    logic                rd_prev_q, rd_prev_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    result_q, result_d;
    logic                is_done_q, is_done_d;
    logic                busy_q, busy_d;
    logic                f_rd_q, f_rd_d;
    logic [ADDR_W-1:0]   f_addr_q, f_addr_d;
    logic [3:0]          w_addr_q, w_addr_d;

    logic [2*DATA_W-1:0] f_ext, w_ext, prod;
    logic [ACC_W-1:0]    prod_ext;
    logic                accept;

    // Window is two rows above and one column left of the anchor.
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [1:0] r,
                                                   input logic [1:0] c);
        tap_addr = b + ADDR_W'(r) * ADDR_W'(ROW_W) + ADDR_W'(c)
                   - ADDR_W'(2 * ROW_W + 1);
    endfunction

    assign f_ext    = {{DATA_W{f_rdata[DATA_W-1]}}, f_rdata};
    assign w_ext    = {{DATA_W{w_rdata[DATA_W-1]}}, w_rdata};
    assign prod     = f_ext * w_ext;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // A held request at the address of the last finished job must not re-run it.
    assign accept = en && (!en_prev_q || !last_valid_q || (feature_baseaddr != last_base_q));

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        row_d        = row_q;
        col_d        = col_q;
        base_d       = base_q;
        last_base_d  = last_base_q;
        last_valid_d = last_valid_q;
        en_prev_d    = en;
        rd_prev_d    = f_rd_q;
        acc_d        = rd_prev_q ? acc_q + prod_ext : acc_q;
        result_d     = result_q;
        is_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    base_d  = feature_baseaddr;
                    acc_d   = '0;
                    tap_d   = 4'd0;
                    row_d   = 2'd0;
                    col_d   = 2'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (tap_q == 4'd8) begin
                    state_d = DRAIN;
                end else begin
                    tap_d = tap_q + 4'd1;
                    if (col_q == 2'd2) begin
                        col_d = 2'd0;
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                result_d  = acc_d;
                is_done_d = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                last_base_d  = base_q;
                last_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with the state.
        busy_d   = (state_d != IDLE);
        f_rd_d   = (state_d == FETCH);
        f_addr_d = f_rd_d ? tap_addr(base_d, row_d, col_d) : '0;
        w_addr_d = f_rd_d ? tap_d : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tap_q        <= 4'd0;
            row_q        <= 2'd0;
            col_q        <= 2'd0;
            base_q       <= '0;
            last_base_q  <= '0;
            last_valid_q <= 1'b0;
            en_prev_q    <= 1'b0;
            rd_prev_q    <= 1'b0;
            acc_q        <= '0;
            result_q     <= '0;
            is_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            f_rd_q       <= 1'b0;
            f_addr_q     <= '0;
            w_addr_q     <= 4'd0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            row_q        <= row_d;
            col_q        <= col_d;
            base_q       <= base_d;
            last_base_q  <= last_base_d;
            last_valid_q <= last_valid_d;
            en_prev_q    <= en_prev_d;
            rd_prev_q    <= rd_prev_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            is_done_q    <= is_done_d;
            busy_q       <= busy_d;
            f_rd_q       <= f_rd_d;
            f_addr_q     <= f_addr_d;
            w_addr_q     <= w_addr_d;
        end
    end

    assign is_done = is_done_q;
    assign busy    = busy_q;
    assign f_rd    = f_rd_q;
    assign f_addr  = f_addr_q;
    assign w_addr  = w_addr_q;
    assign result  = result_q;

endmodule

// File: tb/tb_serial_conv_engine.sv
// tb/tb_serial_conv_engine.sv - scoreboard bench for serial_conv_engine
module tb_serial_conv_engine;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  feature_baseaddr;
    logic        is_done;
    logic        busy;
    logic [7:0]  f_addr;
    logic        f_rd;
    logic [7:0]  f_rdata;
    logic [3:0]  w_addr;
    logic [7:0]  w_rdata;
    logic [19:0] result;

    serial_conv_engine dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .feature_baseaddr (feature_baseaddr),
        .is_done          (is_done),
        .busy             (busy),
        .f_addr           (f_addr),
        .f_rd             (f_rd),
        .f_rdata          (f_rdata),
        .w_addr           (w_addr),
        .w_rdata          (w_rdata),
        .result           (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Memory model: fmode 0 returns the address as data, fmode 1 a constant.
    int fmode = 0;
    int fconst = 0;
    int wconst = 1;

    function automatic logic [7:0] feat_val(input logic [7:0] a);
        logic [7:0] c;
        c = 8'(fconst);
        return (fmode == 0) ? a : c;
    endfunction

    always @(posedge clk) begin
        if (f_rd) begin
            f_rdata <= feat_val(f_addr);
            w_rdata <= 8'(wconst);
        end
    end

    int exp_addr_q[$];
    int exp_tap_q[$];
    int exp_res_q[$];
    int exp_done_cyc_q[$];
    int done_cnt = 0;

    task automatic push_job(input int base, input int acc_cycle);
        int sum;
        int a;
        int fv;
        sum = 0;
        for (int t = 0; t < 9; t++) begin
            a = (base + (t / 3 - 2) * 4 + (t % 3 - 1)) & 255;
            exp_addr_q.push_back(a);
            exp_tap_q.push_back(t);
            if (fmode == 0) fv = (a >= 128) ? a - 256 : a;
            else fv = fconst;
            sum += fv * wconst;
        end
        exp_res_q.push_back(sum);
        exp_done_cyc_q.push_back(acc_cycle + 11);
    endtask

    always @(negedge clk) begin
        if (f_rd) begin
            check("f_rd_expected", int'(exp_addr_q.size() != 0), 1);
            if (exp_addr_q.size() != 0) begin
                check("f_addr", int'(f_addr), exp_addr_q.pop_front());
                check("w_addr", int'(w_addr), exp_tap_q.pop_front());
            end
        end
        if (is_done) begin
            check("is_done_expected", int'(exp_res_q.size() != 0), 1);
            if (exp_res_q.size() != 0) begin
                check("result", int'($signed(result)), exp_res_q.pop_front());
                check("done_cycle", cyc, exp_done_cyc_q.pop_front());
            end
            done_cnt++;
        end
    end

    task automatic wait_done(input int n_before, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > n_before) return;
        end
        check("done_timeout", done_cnt, n_before + 1);
    endtask

    task automatic start_job(input int base);
        int n;
        en = 1'b0;
        @(posedge clk);
        #1;
        feature_baseaddr = 8'(base);
        push_job(base, cyc);
        en = 1'b1;
        n = done_cnt;
        wait_done(n, 40);
    endtask

    initial begin
        int n;
        int k;
        int strides[3] = '{10, 13, 14};
        int exp_res[3] = '{54, 81, 90};

        rst = 1'b1;
        en = 1'b0;
        feature_baseaddr = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_is_done", int'(is_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_f_rd", int'(f_rd), 0);
        check("rst_f_addr", int'(f_addr), 0);
        check("rst_w_addr", int'(w_addr), 0);
        check("rst_result", int'(result), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single job then the four-stride sequence with en held high.
        fmode = 0;
        wconst = 1;
        feature_baseaddr = 8'd9;
        push_job(9, cyc);
        en = 1'b1;
        wait_done(0, 40);
        for (int s = 0; s < 3; s++) begin
            n = done_cnt;
            feature_baseaddr = 8'(strides[s]);
            push_job(strides[s], cyc);
            wait_done(n, 40);
            check("stride_result", int'($signed(result)), exp_res[s]);
        end

        // Held request at an unchanged address must stay idle.
        n = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("hold_result", int'($signed(result)), 90);
        check("hold_busy", int'(busy), 0);
        check("hold_done_cnt", done_cnt, n);

        // Extreme operands.
        fmode = 1;
        fconst = -128;
        wconst = -128;
        start_job(20);
        check("ext_pos", int'($signed(result)), 147456);
        wconst = 127;
        start_job(20);
        check("ext_neg", int'($signed(result)), -146304);

        // Address wrap below zero.
        fconst = 1;
        wconst = 1;
        start_job(1);
        check("wrap_result", int'($signed(result)), 9);

        // Reset in the middle of a job, then re-accept at the same base.
        fmode = 0;
        en = 1'b0;
        @(posedge clk);
        #1;
        feature_baseaddr = 8'd9;
        push_job(9, cyc);
        k = cyc;
        en = 1'b1;
        while (cyc < k + 5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        n = done_cnt;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_f_rd", int'(f_rd), 0);
        check("midrst_result", int'(result), 0);
        check("midrst_is_done", int'(is_done), 0);
        check("midrst_no_done", done_cnt, n);
        exp_addr_q.delete();
        exp_tap_q.delete();
        exp_res_q.delete();
        exp_done_cyc_q.delete();
        push_job(9, cyc);
        rst = 1'b0;
        wait_done(n, 40);
        check("reaccept_result", int'($signed(result)), 45);

        repeat (3) @(posedge clk);
        #1;
        check("addr_q_drained", exp_addr_q.size(), 0);
        check("res_q_drained", exp_res_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_conv_engine.md
# serial_conv_engine

Compute worker on the responder side of the serial-mode stride handshake. Each job is a 3x3 signed multiply-accumulate over the feature memory, anchored at `feature_baseaddr`. The block fetches 9 feature/weight pairs, accumulates them, presents the sum and pulses `is_done` for one cycle. It sits between the serial-mode sequencer, which drives `en`/`feature_baseaddr` and waits on `is_done`, and the feature SRAM and weight ROM.

## Interface
- DATA_W, 8, signed width of feature and weight words
- ACC_W, 20, signed accumulator/result width; 9·128·128 = 147456 < 2^19, so no overflow
- ADDR_W, 8, feature memory address width
- ROW_W, 4, feature-map row pitch in words
- clk  in  1  clock; reset rst is synchronous, active-high
- rst  in  1  synchronous active-high reset
- en  in  1  level job request from sequencer; may stay high across back-to-back jobs
- feature_baseaddr  in  ADDR_W  window anchor for the job, sampled at accept
- is_done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after accept through the DONE cycle
- f_addr  out  ADDR_W  feature SRAM read address
- f_rd  out  1  feature SRAM read strobe
- f_rdata  in  DATA_W  feature data, valid 1 cycle after f_rd
- w_addr  out  4  weight ROM tap index 0..8
- w_rdata  in  DATA_W  weight data, valid 1 cycle after f_rd
- result  out  ACC_W  signed sum of the last completed job, held until the next DONE

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- Accept condition, in IDLE, all of:
  - en=1;
  - either en was 0 in the previous cycle, or feature_baseaddr ≠ last_base.
- Accept actions:
  - latch base;
  - clear the accumulator;
  - tap=0;
  - go to FETCH.
- last_base behaviour:
  - last_base = base of the last completed job;
  - it is invalid after reset, so the first en=1 always accepts;
  - a request held at an unchanged address after completion never re-triggers a job.
- FETCH (9 cycles, tap 0..8, r=tap/3, c=tap%3):
  - f_rd=1;
  - w_addr=tap;
  - f_addr = base + (r−2)·ROW_W + (c−1), computed modulo 2^ADDR_W.
  - Example, base=9, ROW_W=4: addresses 0,1,2,4,5,6,8,9,10.
  - After tap 8, go to DRAIN.
- Accumulate:
  - in every cycle following an f_rd=1 cycle, acc += f_rdata × w_rdata;
  - the product is signed and sign-extended to ACC_W.
- DRAIN (1 cycle):
  - the last product is added;
  - result ← final acc at the end of DRAIN.
- DONE (1 cycle):
  - is_done=1;
  - last_base ← base;
  - next state is IDLE.
- Behaviour while busy:
  - en and feature_baseaddr are ignored until IDLE;
  - en falling mid-job does not abort the job.
- rst (any state, including mid-job):
  - state IDLE, tap=0, acc=0, last_base invalid, en history=0;
  - outputs go to reset values; no is_done is issued for the aborted job.
- Reset values:
  - is_done=0, busy=0, f_rd=0, f_addr=0, w_addr=0, result=0.
- Outside FETCH:
  - f_rd=0, f_addr=0, w_addr=0.

## Timing
- Accept at clock edge k, i.e. IDLE in cycle k with the accept condition true.
- FETCH: cycles k+1..k+9.
- DRAIN: cycle k+10.
- DONE: cycle k+11, with is_done=1 and result valid.
- Accept to is_done is 11 cycles.
- The earliest re-accept is cycle k+12 (IDLE), if the sequencer has changed feature_baseaddr by then.
- A sequencer that advances its address the cycle after seeing is_done gets back-to-back jobs with one IDLE cycle between them.
- Memory contract:
  - read latency is exactly 1 cycle;
  - f_rdata and w_rdata are sampled in cycles k+2..k+10.
- busy is 1 for cycles k+1..k+11.

## Test plan
- Single job:
  - stimulus: base=9, features = address value, all weights=1;
  - response: f_addr sequence 0,1,2,4,5,6,8,9,10; result=45; is_done in exactly cycle k+11.
- Four-stride sequence:
  - stimulus: en held high, base 9→10→13→14, each changed the cycle after is_done; features = address value, weights=1;
  - response: results 45, 54, 81, 90; four is_done pulses, each 12 cycles apart.
- Hold without change:
  - stimulus: after the base=14 job, en held high with base=14 for 20 cycles;
  - response: no new f_rd and no is_done; result stays 90.
- Extreme values:
  - stimulus: all features=−128, all weights=−128;
  - response: result=147456.
  - stimulus: features=−128, weights=127;
  - response: result=−146304.
- Address wrap:
  - stimulus: base=1;
  - response: first f_addr=248 (1−8−1 mod 256), last f_addr=2.
- Reset mid-job:
  - stimulus: rst at cycle k+5;
  - response: next cycle busy=0, f_rd=0, result=0, no is_done;
  - stimulus: afterwards, en held at the same base;
  - response: the job is accepted again, because last_base is invalid.
